// File: rtl/pll_reset_seq.sv
// PLL bring-up sequencer: pulses the PLL reset, filters its lock flag, and
// releases the core reset only after a stable lock plus a settling delay.
module pll_reset_seq #(
   parameter int RST_PULSE    = 16,
   parameter int LOCK_TIMEOUT = 1048576,
   parameter int LOCK_FILTER  = 1024,
   parameter int RELEASE_DLY  = 256
) (
   input  logic       clk_74a,
   input  logic       reset_n,
   input  logic       pll_locked,
   output logic       pll_rst,
   output logic       core_reset_n,
   output logic       pll_ok,
   output logic [3:0] retry_count
);

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Each state stops at its terminal count minus one, so max-1 must fit.
   localparam int CNT_MAX = max2(max2(RST_PULSE, LOCK_TIMEOUT), max2(LOCK_FILTER, RELEASE_DLY));
   localparam int CW      = $clog2(CNT_MAX);

   typedef logic [CW-1:0] cnt_t;

   localparam cnt_t RST_LAST     = cnt_t'(RST_PULSE - 1);
   localparam cnt_t TIMEOUT_LAST = cnt_t'(LOCK_TIMEOUT - 1);
   localparam cnt_t FILTER_LAST  = cnt_t'(LOCK_FILTER - 1);
   localparam cnt_t DELAY_LAST   = cnt_t'(RELEASE_DLY - 1);

   typedef enum logic [2:0] {
      ST_PLL_RST,
      ST_WAIT_LOCK,
      ST_FILTER,
      ST_DELAY,
      ST_RUN
   } state_t;

   state_t     state_q;
   cnt_t       cnt_q;
   logic [1:0] sync_q;
   logic       pll_rst_q;
   logic       core_reset_n_q;
   logic       pll_ok_q;
   logic [3:0] retry_q;
   logic [3:0] retry_d;
   logic       lk;

   // pll_locked comes from the PLL's own clock domain.
   always_ff @(posedge clk_74a or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= 2'b00;
      end else begin
         // NOTE: non-blocking so both flops sample the pre-edge values and form a real two-stage chain.
         sync_q <= {sync_q[0], pll_locked};
      end
   end

   assign lk = sync_q[1];

   always_comb begin
      // NOTE: default first so every path assigns retry_d and no latch is inferred.
      retry_d = retry_q;
      if (retry_q != 4'd15) begin
         retry_d = retry_q + 4'd1;
      end
   end

   always_ff @(posedge clk_74a or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= ST_PLL_RST;
         cnt_q          <= '0;
         pll_rst_q      <= 1'b1;
         core_reset_n_q <= 1'b0;
         pll_ok_q       <= 1'b0;
         retry_q        <= 4'd0;
      end else begin
         case (state_q)
            ST_PLL_RST: begin
               if (cnt_q == RST_LAST) begin
                  state_q   <= ST_WAIT_LOCK;
                  cnt_q     <= '0;
                  pll_rst_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + cnt_t'(1);
               end
            end
            ST_WAIT_LOCK: begin
               // Lock is tested first so it beats a coincident timeout.
               if (lk) begin
                  state_q <= ST_FILTER;
                  cnt_q   <= '0;
               end else if (cnt_q == TIMEOUT_LAST) begin
                  state_q   <= ST_PLL_RST;
                  cnt_q     <= '0;
                  pll_rst_q <= 1'b1;
                  retry_q   <= retry_d;
               end else begin
                  cnt_q <= cnt_q + cnt_t'(1);
               end
            end
            ST_FILTER: begin
               if (!lk) begin
                  state_q <= ST_WAIT_LOCK;
                  cnt_q   <= '0;
               end else if (cnt_q == FILTER_LAST) begin
                  state_q <= ST_DELAY;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + cnt_t'(1);
               end
            end
            ST_DELAY: begin
               if (!lk) begin
                  state_q <= ST_WAIT_LOCK;
                  cnt_q   <= '0;
               end else if (cnt_q == DELAY_LAST) begin
                  state_q        <= ST_RUN;
                  cnt_q          <= '0;
                  core_reset_n_q <= 1'b1;
                  pll_ok_q       <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + cnt_t'(1);
               end
            end
            ST_RUN: begin
               if (!lk) begin
                  state_q        <= ST_PLL_RST;
                  cnt_q          <= '0;
                  pll_rst_q      <= 1'b1;
                  core_reset_n_q <= 1'b0;
                  pll_ok_q       <= 1'b0;
                  retry_q        <= retry_d;
               end
            end
            default: begin
               state_q        <= ST_PLL_RST;
               cnt_q          <= '0;
               pll_rst_q      <= 1'b1;
               core_reset_n_q <= 1'b0;
               pll_ok_q       <= 1'b0;
            end
         endcase
      end
   end

   assign pll_rst      = pll_rst_q;
   assign core_reset_n = core_reset_n_q;
   assign pll_ok       = pll_ok_q;
   assign retry_count  = retry_q;

endmodule

// File: doc/pll_reset_seq.md
PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

Interface
REQ-001 SHALL provide parameter RST_PULSE, default 16: pll_rst assertion width in clk_74a cycles (>=2).
REQ-002 SHALL provide parameter LOCK_TIMEOUT, default 1048576: cycles allowed in WAIT_LOCK before the PLL is reset again.
REQ-003 SHALL provide parameter LOCK_FILTER, default 1024: consecutive synchronized-locked cycles required to accept lock.
REQ-004 SHALL provide parameter RELEASE_DLY, default 256: cycles from accepted lock to core_reset_n deassertion.
REQ-005 SHALL have port clk_74a, input, 1: sole clock, 74.25 MHz reference that also feeds the PLL.
REQ-006 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port pll_locked, input, 1: PLL lock flag, asynchronous to clk_74a.
REQ-008 SHALL have port pll_rst, output, 1: active-high PLL reset, registered.
REQ-009 SHALL have port core_reset_n, output, 1: active-low reset for logic on the PLL output clocks, registered.
REQ-010 SHALL have port pll_ok, output, 1: high only in RUN.
REQ-011 SHALL have port retry_count, output, 4: number of PLL resets issued after the first, saturating at 15.

Function
REQ-012 SHALL synchronize pll_locked through a 2-flop synchronizer; all logic uses the synchronized value (lk).
REQ-013 SHALL implement states PLL_RST, WAIT_LOCK, FILTER, DELAY, RUN, with one shared cycle counter cleared on every state change.
REQ-014 In PLL_RST: pll_rst=1; after exactly RST_PULSE cycles, go to WAIT_LOCK.
REQ-015 In WAIT_LOCK: pll_rst=0; if lk=1, go to FILTER; if the counter reaches LOCK_TIMEOUT-1 with lk=0, go to PLL_RST and increment retry_count (saturating).
REQ-016 In FILTER: if lk=0 on any cycle, return to WAIT_LOCK (timeout counter restarts); after LOCK_FILTER consecutive lk=1 cycles, go to DELAY.
REQ-017 In DELAY: if lk=0, go to WAIT_LOCK; after RELEASE_DLY cycles, go to RUN.
REQ-018 In RUN: core_reset_n=1 and pll_ok=1; if lk=0 for one cycle, go to PLL_RST, increment retry_count, and drive core_reset_n=0 on the next edge.
REQ-019 core_reset_n SHALL be 0 in every state except RUN; its only transition to 1 is on entry to RUN.
REQ-020 pll_ok SHALL equal (state==RUN), registered together with core_reset_n.
REQ-021 When the timeout and lk=1 occur in the same cycle in WAIT_LOCK, lk=1 SHALL win, with transition to FILTER.
REQ-022 The counter SHALL be wide enough for max(LOCK_TIMEOUT, LOCK_FILTER, RELEASE_DLY, RST_PULSE) and SHALL never wrap inside a state.
REQ-023 retry_count SHALL never wrap; at 15, further retries leave it at 15.

Reset
REQ-024 reset_n=0 SHALL asynchronously force state=PLL_RST, counter=0, pll_rst=1, core_reset_n=0, pll_ok=0, retry_count=0, synchronizer flops=0.
REQ-025 After reset_n rises, the PLL_RST pulse SHALL last the full RST_PULSE cycles, counted from the first clock edge with reset_n=1.
REQ-026 Assertion of reset_n mid-operation, including in RUN, SHALL immediately drop core_reset_n and pll_ok, with no clock required.

Verification (bench parameters: RST_PULSE=4, LOCK_TIMEOUT=64, LOCK_FILTER=8, RELEASE_DLY=16)
REQ-027 Scenario: release reset_n, raise pll_locked 10 cycles later and hold it -> pll_rst high for 4 cycles; core_reset_n and pll_ok rise 2 (sync) + 8 + 16 cycles (±1 for state entry) after pll_locked rises; retry_count=0.
REQ-028 Scenario: hold pll_locked=0 -> pll_rst repeats 4-cycle pulses every 68 cycles; retry_count increments 1,2,... and stays at 15.
REQ-029 Scenario: pll_locked glitches low for 2 cycles during FILTER -> no deassertion of core_reset_n; filter restarts and 8 fresh lk cycles are needed.
REQ-030 Scenario: in RUN, drop pll_locked for 3 cycles -> core_reset_n=0 within 4 cycles of the drop; 4-cycle pll_rst pulse issued; retry_count=1; relock returns to RUN.
REQ-031 Scenario: assert reset_n=0 between clock edges while in RUN -> core_reset_n=0, pll_ok=0, pll_rst=1 and retry_count=0 immediately.
REQ-032 Scenario: in WAIT_LOCK, raise lk on the timeout cycle -> go to FILTER, no pll_rst pulse, retry_count unchanged.
